// File: rtl/nap_alarm_trigger.sv
// ============================================================================
// nap_alarm_trigger : wake-alarm FSM (IDLE/ARMED/RINGING/DONE) with BCD
//                     time match, timed ring with buzzer pattern, cancel/ack.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nap_alarm_trigger #(
    parameter int unsigned RING_SECONDS = 30,
    parameter logic [1:0]  IDLE_ST      = 2'd0,
    parameter logic [1:0]  ARMED_ST     = 2'd1,
    parameter logic [1:0]  RING_ST      = 2'd2,
    parameter logic [1:0]  DONE_ST      = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_complete,
    input  logic [23:0] target_time,
    input  logic [23:0] cur_time,
    input  logic        sec_tick,
    input  logic        sharp,
    output logic        armed,
    output logic        alarm,
    output logic        buzz,
    output logic        nap_done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = IDLE_ST,
        S_ARMED = ARMED_ST,
        S_RING  = RING_ST,
        S_DONE  = DONE_ST
    } state_t;

    localparam logic [7:0] RING_LOAD = 8'(RING_SECONDS);

    state_t      cur_state;
    state_t      nxt_state;
    logic [23:0] target_reg;
    logic [7:0]  ring_cnt;
    logic [7:0]  nxt_cnt;
    logic        buzz_reg;
    logic        nxt_buzz;
    logic        armed_reg;
    logic        alarm_reg;
    logic        done_reg;
    logic        time_match;

    assign time_match = (target_reg == cur_time);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= S_IDLE;
            target_reg <= 24'd0;
            ring_cnt   <= 8'd0;
            buzz_reg   <= 1'b0;
            armed_reg  <= 1'b0;
            alarm_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ring_cnt  <= nxt_cnt;
            buzz_reg  <= nxt_buzz;
            armed_reg <= (nxt_state == S_ARMED);
            alarm_reg <= (nxt_state == S_RING);
            done_reg  <= (nxt_state == S_DONE);
            if (set_complete) begin
                target_reg <= target_time;
            end
        end
    end

    // set_complete outranks sharp, which outranks match/timeout.
    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = ring_cnt;
        nxt_buzz  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (set_complete) begin
                    nxt_state = S_ARMED;
                end
            end
            S_ARMED: begin
                if (set_complete) begin
                    nxt_state = S_ARMED;
                end else if (sharp) begin
                    nxt_state = S_IDLE;
                end else if (time_match) begin
                    nxt_state = S_RING;
                    nxt_cnt   = RING_LOAD;
                    nxt_buzz  = 1'b1;
                end
            end
            S_RING: begin
                nxt_buzz = buzz_reg;
                if (set_complete) begin
                    nxt_state = S_ARMED;
                    nxt_buzz  = 1'b0;
                end else if (sharp) begin
                    nxt_state = S_DONE;
                    nxt_buzz  = 1'b0;
                end else if (sec_tick) begin
                    if (ring_cnt != 8'd0) begin
                        nxt_cnt = ring_cnt - 8'd1;
                    end
                    if (ring_cnt == 8'd1) begin
                        nxt_state = S_DONE;
                        nxt_buzz  = 1'b0;
                    end else begin
                        nxt_buzz = ~buzz_reg;
                    end
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    assign armed    = armed_reg;
    assign alarm    = alarm_reg;
    assign buzz     = buzz_reg;
    assign nap_done = done_reg;
    assign state    = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_nap_alarm_trigger.sv
// ============================================================================
// tb_nap_alarm_trigger : directed self-checking bench for nap_alarm_trigger.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nap_alarm_trigger;

    logic        clk;
    logic        rst;
    logic        set_complete;
    logic [23:0] target_time;
    logic [23:0] cur_time;
    logic        sec_tick;
    logic        sharp;
    logic        armed;
    logic        alarm;
    logic        buzz;
    logic        nap_done;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    nap_alarm_trigger #(
        .RING_SECONDS(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .set_complete (set_complete),
        .target_time  (target_time),
        .cur_time     (cur_time),
        .sec_tick     (sec_tick),
        .sharp        (sharp),
        .armed        (armed),
        .alarm        (alarm),
        .buzz         (buzz),
        .nap_done     (nap_done),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] st, input logic a,
                            input logic al, input logic bz, input logic nd);
        chk({tag, ".state"},    32'(state),    32'(st));
        chk({tag, ".armed"},    32'(armed),    32'(a));
        chk({tag, ".alarm"},    32'(alarm),    32'(al));
        chk({tag, ".buzz"},     32'(buzz),     32'(bz));
        chk({tag, ".nap_done"}, 32'(nap_done), 32'(nd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        set_complete = 1'b0;
        target_time  = 24'h0;
        cur_time     = 24'h0;
        sec_tick     = 1'b0;
        sharp        = 1'b0;
        tick();
        tick();
        chk_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Arm for 00:00:05 and count up to it.
        cur_time = 24'h000000; target_time = 24'h000005; set_complete = 1'b1;
        tick();
        set_complete = 1'b0;
        chk_outs("arm5", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 1; s <= 4; s++) begin
            cur_time = 24'(s);
            tick();
        end
        chk_outs("pre_match", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cur_time = 24'h000005;
        tick();
        chk_outs("ring5", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Timeout after three ticks; buzz 1 -> 0 -> 1 -> DONE.
        cur_time = 24'h000006; sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        chk_outs("tick1", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_outs("no_tick", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        sec_tick = 1'b1;
        tick();
        chk_outs("tick2", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        sec_tick = 1'b0;
        chk_outs("tick3_done", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("after_done", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // sharp acknowledges a ringing alarm; sharp in IDLE is ignored.
        cur_time = 24'h000100; target_time = 24'h000101; set_complete = 1'b1;
        tick();
        set_complete = 1'b0;
        cur_time = 24'h000101;
        tick();
        chk_outs("ring101", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        sharp = 1'b1;
        tick();
        sharp = 1'b0;
        chk_outs("ack_done", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("ack_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        sharp = 1'b1;
        tick();
        sharp = 1'b0;
        chk_outs("sharp_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Re-target in the same cycle the old target matches.
        cur_time = 24'h115959; target_time = 24'h120000; set_complete = 1'b1;
        tick();
        cur_time = 24'h120000; target_time = 24'h120030;
        tick();
        set_complete = 1'b0;
        chk_outs("retarget", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_outs("old_match", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cur_time = 24'h120029;
        tick();
        chk_outs("pre_1230", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cur_time = 24'h120030;
        tick();
        chk_outs("ring1230", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Re-arm while ringing beats sharp; then sharp cancels ARMED.
        target_time = 24'h130000; set_complete = 1'b1; sharp = 1'b1;
        tick();
        set_complete = 1'b0;
        chk_outs("rearm", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        sharp = 1'b0;
        chk_outs("cancel", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // sharp beats a simultaneous match in ARMED.
        cur_time = 24'h000259; target_time = 24'h000300; set_complete = 1'b1;
        tick();
        set_complete = 1'b0;
        cur_time = 24'h000300; sharp = 1'b1;
        tick();
        sharp = 1'b0;
        chk_outs("sharp_vs_match", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-RINGING; the match afterwards must not ring.
        cur_time = 24'h000159; target_time = 24'h000200; set_complete = 1'b1;
        tick();
        set_complete = 1'b0;
        cur_time = 24'h000200;
        tick();
        chk_outs("ring200", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_outs("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_outs("post_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_time = 24'h000000;
        tick();
        chk_outs("post_rst_zero", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
